timer_counter: RTL

//   Counting core of the timer. Consumes the control fields decoded by the timer

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_prescaler.sv | 53 +++++
 rtl/timer_counter.sv | 68 ++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared constants and the prescaler exponent clamp for the timer counting core.
package timer_pkg;

  localparam int         TIMER_CNT_W   = 64;
  localparam logic [3:0] TIMER_DIV_MAX = 4'd8;
  localparam int         TIMER_PRE_W   = 8;

  // Exponents above the legal maximum saturate rather than alias.
  function automatic logic [3:0] div_clamp(input logic [3:0] val, input logic [3:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: tracks the divide phase and emits the per-cycle increment strobe.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter logic [3:0] DIV_MAX = TIMER_DIV_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       timer_en,
  input  logic       div_en,
  input  logic [3:0] div_val,
  input  logic       count_clr,
  input  logic       halt,
  output logic       inc
);

  localparam logic [TIMER_PRE_W:0] ONE = 1;

  logic [TIMER_PRE_W-1:0] pre_cnt;
  logic [3:0]             div_shadow;
  logic [3:0]             div_eff;
  logic [TIMER_PRE_W:0]   pre_last;
  logic                   at_last;
  logic                   restart;

  always_comb begin
    div_eff  = div_clamp(div_val, DIV_MAX);
    pre_last = (ONE << div_eff) - ONE;
    at_last  = ({1'b0, pre_cnt} == pre_last);
    // A new divide ratio always starts a fresh period.
    restart  = ~timer_en | ~div_en | count_clr | (div_val != div_shadow);
    inc      = timer_en & ~count_clr & ~halt & (div_en ? at_last : 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      div_shadow <= '0;
    end else begin
      div_shadow <= div_val;
      if (restart) begin
        pre_cnt <= '0;
      end else if (halt) begin
        pre_cnt <= pre_cnt;
      end else if (at_last) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_counter.sv
// 64-bit timer count with prescaler, half-word software load, clear and tick strobe.
// Optional debug freeze is enabled by defining TIMER_DBG_HALT_EN.
module timer_counter
  import timer_pkg::*;
#(
  parameter int         CNT_W   = TIMER_CNT_W,
  parameter logic [3:0] DIV_MAX = TIMER_DIV_MAX
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [3:0]       div_val,
  input  logic             count_clr,
  input  logic             ld_lo,
  input  logic             ld_hi,
  input  logic [31:0]      ld_data,
`ifdef TIMER_DBG_HALT_EN
  input  logic             dbg_halt,
`endif
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  logic inc;
  logic load;
  logic halt;

`ifdef TIMER_DBG_HALT_EN
  assign halt = dbg_halt;
`else
  assign halt = 1'b0;
`endif

  assign load = ld_lo | ld_hi;

  timer_prescaler #(
    .DIV_MAX(DIV_MAX)
  ) u_prescaler (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .count_clr(count_clr),
    .halt     (halt),
    .inc      (inc)
  );

  // Clear beats load beats increment; an increment lost to a load raises no tick.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= inc & ~load;
      if (count_clr) begin
        count <= '0;
      end else if (load) begin
        if (ld_lo) count[31:0]       <= ld_data;
        if (ld_hi) count[CNT_W-1:32] <= ld_data;
      end else if (inc) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
